// File: rtl/wb_crypto_pkg.sv
// Shared register map, bit positions and sequencer states for the Wishbone crypto slave.
package wb_crypto_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_KEY    = 8'h10;
  localparam logic [7:0] OFF_DIN    = 8'h40;
  localparam logic [7:0] OFF_DOUT   = 8'h80;

  localparam int CTRL_START   = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Byte-lane merge of a write into an existing 32-bit word.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb_slave_if.sv
// Wishbone front end: address decode, one-cycle ack, latched write port and registered read data.
module wb_slave_if #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  rd_off,
  input  logic [31:0] rd_data,
  output logic        wr_en,
  output logic [7:0]  wr_off,
  output logic [3:0]  wr_sel,
  output logic [31:0] wr_data
);

  logic        ack_reg;
  logic        we_reg;
  logic [31:0] dat_reg;
  logic        hit;
  logic        req;

  assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  // Masking with ack_reg makes a held strobe re-request only every second cycle.
  assign req = wbs_cyc_i && wbs_stb_i && hit && !ack_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_reg <= 1'b0;
      we_reg  <= 1'b0;
      dat_reg <= '0;
      wr_off  <= '0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      ack_reg <= req;
      dat_reg <= (req && !wbs_we_i) ? rd_data : 32'h0;
      if (req) begin
        we_reg  <= wbs_we_i;
        wr_off  <= wbs_adr_i[7:0];
        wr_sel  <= wbs_sel_i;
        wr_data <= wbs_dat_i;
      end
    end
  end

  assign rd_off    = wbs_adr_i[7:0];
  assign wr_en     = ack_reg && we_reg;
  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;

endmodule

// File: rtl/wb_crypto_slave.sv
// Register bank and start/done sequencer placed between the Wishbone bus and a block-cipher core.
module wb_crypto_slave import wb_crypto_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          KEY_WORDS = 3,
  parameter int          BLK_WORDS = 2,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic                   core_start_o,
  output logic [32*KEY_WORDS-1:0] core_key_o,
  output logic [32*BLK_WORDS-1:0] core_din_o,
  input  logic [32*BLK_WORDS-1:0] core_dout_i,
  input  logic                   core_done_i,
  output logic                   irq_o,
  output logic                   done_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic        wr_en;
  logic [7:0]  wr_off, rd_off;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data, rd_data;

  state_t        state_reg, state_next;
  logic          irq_en_reg, irq_en_next;
  logic          done_reg, done_next;
  logic          tmo_reg, tmo_next;
  logic          start_reg, start_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          dout_ld;
  logic          idle, ctrl_wr, status_wr;

  logic [31:0] key_reg  [KEY_WORDS];
  logic [31:0] din_reg  [BLK_WORDS];
  logic [31:0] dout_reg [BLK_WORDS];
  logic [KEY_WORDS-1:0] key_we;
  logic [BLK_WORDS-1:0] din_we;

  wb_slave_if #(.BASE_ADDR(BASE_ADDR)) u_if (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .rd_off    (rd_off),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_off    (wr_off),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data)
  );

  assign idle      = (state_reg == ST_IDLE);
  assign ctrl_wr   = wr_en && (wr_off == OFF_CTRL) && wr_sel[0];
  assign status_wr = wr_en && (wr_off == OFF_STATUS) && wr_sel[0];

  // Operand registers are frozen while the core is running.
  genvar gi;
  generate
    for (gi = 0; gi < KEY_WORDS; gi++) begin : g_key
      assign key_we[gi] = wr_en && idle && (wr_off == OFF_KEY + 8'(4*gi));
      assign core_key_o[32*gi +: 32] = key_reg[gi];
    end
    for (gi = 0; gi < BLK_WORDS; gi++) begin : g_blk
      assign din_we[gi] = wr_en && idle && (wr_off == OFF_DIN + 8'(4*gi));
      assign core_din_o[32*gi +: 32] = din_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    irq_en_next = irq_en_reg;
    done_next   = done_reg;
    tmo_next    = tmo_reg;
    start_next  = 1'b0;
    cnt_next    = cnt_reg;
    dout_ld     = 1'b0;
    if (ctrl_wr) irq_en_next = wr_data[CTRL_IRQ_EN];
    if (status_wr) begin
      if (wr_data[STAT_DONE])    done_next = 1'b0;
      if (wr_data[STAT_TIMEOUT]) tmo_next  = 1'b0;
    end
    // Completion is applied after the W1C so a same-cycle clear loses.
    case (state_reg)
      ST_IDLE: begin
        if (ctrl_wr && wr_data[CTRL_START]) begin
          start_next = 1'b1;
          done_next  = 1'b0;
          tmo_next   = 1'b0;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (core_done_i) begin
          dout_ld    = 1'b1;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else if (TIMEOUT != 0 && cnt_reg == TO_LAST) begin
          tmo_next   = 1'b1;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg  <= ST_IDLE;
      irq_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      tmo_reg    <= 1'b0;
      start_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      irq_en_reg <= irq_en_next;
      done_reg   <= done_next;
      tmo_reg    <= tmo_next;
      start_reg  <= start_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int k = 0; k < KEY_WORDS; k++) key_reg[k] <= '0;
      for (int k = 0; k < BLK_WORDS; k++) begin
        din_reg[k]  <= '0;
        dout_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < KEY_WORDS; k++)
        if (key_we[k]) key_reg[k] <= apply_sel(key_reg[k], wr_data, wr_sel);
      for (int k = 0; k < BLK_WORDS; k++) begin
        if (din_we[k]) din_reg[k] <= apply_sel(din_reg[k], wr_data, wr_sel);
        if (dout_ld)   dout_reg[k] <= core_dout_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_off)
      OFF_CTRL:   rd_data[CTRL_IRQ_EN] = irq_en_reg;
      OFF_STATUS: begin
        rd_data[STAT_TIMEOUT] = tmo_reg;
        rd_data[STAT_DONE]    = done_reg;
        rd_data[STAT_BUSY]    = (state_reg == ST_RUN);
      end
      default: ;
    endcase
    for (int k = 0; k < KEY_WORDS; k++)
      if (rd_off == OFF_KEY + 8'(4*k)) rd_data = key_reg[k];
    for (int k = 0; k < BLK_WORDS; k++) begin
      if (rd_off == OFF_DIN + 8'(4*k))  rd_data = din_reg[k];
      if (rd_off == OFF_DOUT + 8'(4*k)) rd_data = dout_reg[k];
    end
  end

  assign core_start_o = start_reg;
  assign done_o       = done_reg;
  assign irq_o        = done_reg && irq_en_reg;

endmodule
